ccm_pixel_packer: RTL and testbench

Front-end feeder for the colour-correction pipeline. Accepts one 12-bit component word per transfer (R, G, B, AUX0, AUX1, AUX2), assembles six words into the 72-bit packed pixel, and offers it to the first CCM stage through the standard `i_r_ready`/`u_r_ready` handshake. A small output FIFO decouples word arrival from downstream stalls. A start-of-pixel flag provides framing recovery.

---
 rtl/ccm_pixel_packer_if.sv | 26 ++
 rtl/ccm_pixel_packer.sv | 89 ++++++++
 tb/tb_ccm_pixel_packer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccm_pixel_packer_if.sv
// Word-side and pixel-side handshake bundle for ccm_pixel_packer.
// The slave modport is the packer; the master modport is whatever feeds and drains it.
interface ccm_pixel_packer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 2
);
  logic                            u_i_ready;
  logic [DATA_WIDTH-1:0]           word_in;
  logic                            sop;
  logic                            i_i_ready;
  logic                            u_r_ready;
  logic [6*DATA_WIDTH-1:0]         data_out;
  logic                            i_r_ready;
  logic [$clog2(FIFO_DEPTH):0]     level;
  logic                            framing_error;

  modport master (
    output u_i_ready, word_in, sop, u_r_ready,
    input  i_i_ready, data_out, i_r_ready, level, framing_error
  );

  modport slave (
    input  u_i_ready, word_in, sop, u_r_ready,
    output i_i_ready, data_out, i_r_ready, level, framing_error
  );
endinterface

// File: rtl/ccm_pixel_packer.sv
// Assembles six DATA_WIDTH component words into one packed pixel (R first, MSBs)
// and queues finished pixels in a small FIFO ahead of CCM stage 0.
module ccm_pixel_packer #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  ccm_pixel_packer_if.slave   bus
);
  localparam int W   = DATA_WIDTH;
  localparam int PIX = 6 * DATA_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  logic [2:0]       wcnt;
  logic [5*W-1:0]   asm_q;
  logic [PIX-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [LW-1:0]    level_q;
  logic             fe_q;

  logic wacc;
  logic pdeq;
  logic enq;

  assign bus.i_i_ready     = (level_q != LW'(FIFO_DEPTH));
  assign bus.i_r_ready     = (level_q != '0);
  assign bus.data_out      = bus.i_r_ready ? mem[rd_ptr] : '0;
  assign bus.level         = level_q;
  assign bus.framing_error = fe_q;

  assign wacc = bus.u_i_ready && bus.i_i_ready;
  assign pdeq = bus.i_r_ready && bus.u_r_ready;
  assign enq  = wacc && !bus.sop && (wcnt == 3'd5);

  // Word assembly and framing; the sixth word bypasses asm_q straight into the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt  <= 3'd0;
      asm_q <= '0;
      fe_q  <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      if (wacc) begin
        if (bus.sop) begin
          asm_q <= {bus.word_in, {(4*W){1'b0}}};
          wcnt  <= 3'd1;
          fe_q  <= (wcnt != 3'd0);
        end else if (wcnt == 3'd0) begin
          fe_q <= 1'b1;
        end else if (wcnt == 3'd5) begin
          wcnt <= 3'd0;
        end else begin
          case (wcnt)
            3'd1:    asm_q[4*W-1:3*W] <= bus.word_in;
            3'd2:    asm_q[3*W-1:2*W] <= bus.word_in;
            3'd3:    asm_q[2*W-1:W]   <= bus.word_in;
            3'd4:    asm_q[W-1:0]     <= bus.word_in;
            default: ;
          endcase
          wcnt <= wcnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (enq)  wr_ptr <= wr_ptr + 1'b1;
      if (pdeq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pdeq})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: data_out is forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && enq) mem[wr_ptr] <= {asm_q, bus.word_in};
  end
endmodule

// File: tb/tb_ccm_pixel_packer.sv
// Directed bench for ccm_pixel_packer: packing, backpressure, framing recovery,
// pointer wrap and mid-operation reset, with expected pixels computed in the bench.
module tb_ccm_pixel_packer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ccm_pixel_packer_if #(.DATA_WIDTH(12), .FIFO_DEPTH(2)) bus ();

  ccm_pixel_packer #(.DATA_WIDTH(12), .FIFO_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [71:0] rx_q[$];
  int          fe_count  = 0;
  int          max_level = 0;
  bit          rand_en   = 1'b0;
  int          fe0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.i_r_ready && bus.u_r_ready) rx_q.push_back(bus.data_out);
      if (bus.framing_error) fe_count++;
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] word_of(input int p, input int j);
    return 12'((j + 1) * 256 + p);
  endfunction

  function automatic logic [71:0] pix_of(input int p);
    return {word_of(p, 0), word_of(p, 1), word_of(p, 2),
            word_of(p, 3), word_of(p, 4), word_of(p, 5)};
  endfunction

  task automatic send_word(input logic [11:0] w, input logic s);
    int k;
    bus.u_i_ready = 1'b1;
    bus.word_in   = w;
    bus.sop       = s;
    k = 0;
    while (!bus.i_i_ready && k < 200) begin
      tick();
      k++;
    end
    if (!bus.i_i_ready) check("accept_timeout", 72'(bus.i_i_ready), 72'd1);
    tick();
    bus.u_i_ready = 1'b0;
    bus.sop       = 1'b0;
  endtask

  task automatic send_words(input int p, input int first, input int last);
    for (int j = first; j <= last; j++) send_word(word_of(p, j), j == 0);
  endtask

  task automatic send_pixel(input int p);
    send_words(p, 0, 5);
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 100) begin
      tick();
      k++;
    end
    check("rx_count", 72'(rx_q.size()), 72'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.u_i_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.u_i_ready = 1'b0;
    bus.word_in   = '0;
    bus.sop       = 1'b0;
    bus.u_r_ready = 1'b0;
    reset         = 1'b1;
    #1;
    do_reset();

    check("rst_i_r_ready", 72'(bus.i_r_ready), 72'd0);
    check("rst_data_out",  bus.data_out,       72'd0);
    check("rst_level",     72'(bus.level),     72'd0);
    check("rst_i_i_ready", 72'(bus.i_i_ready), 72'd1);
    check("rst_fe",        72'(bus.framing_error), 72'd0);

    // Basic packing
    bus.u_r_ready = 1'b1;
    fe0 = fe_count;
    rx_q.delete();
    send_word(12'h111, 1'b1);
    send_word(12'h222, 1'b0);
    send_word(12'h333, 1'b0);
    send_word(12'h444, 1'b0);
    send_word(12'h555, 1'b0);
    send_word(12'h666, 1'b0);
    check("basic_valid", 72'(bus.i_r_ready), 72'd1);
    check("basic_data",  bus.data_out, 72'h111222333444555666);
    check("basic_level", 72'(bus.level), 72'd1);
    tick();
    check("basic_drained", 72'(bus.i_r_ready), 72'd0);
    check("basic_no_fe", 72'(fe_count - fe0), 72'd0);

    // Backpressure / full
    bus.u_r_ready = 1'b0;
    rx_q.delete();
    send_pixel(1);
    send_pixel(2);
    check("full_level",     72'(bus.level),     72'd2);
    check("full_i_i_ready", 72'(bus.i_i_ready), 72'd0);
    check("full_head",      bus.data_out,       pix_of(1));
    fork
      send_pixel(3);
      begin
        repeat (8) tick();
        check("stall_level",     72'(bus.level),     72'd2);
        check("stall_i_i_ready", 72'(bus.i_i_ready), 72'd0);
        check("stall_head",      bus.data_out,       pix_of(1));
        bus.u_r_ready = 1'b1;
      end
    join
    wait_rx(3);
    check("bp_pix0", rx_q[0], pix_of(1));
    check("bp_pix1", rx_q[1], pix_of(2));
    check("bp_pix2", rx_q[2], pix_of(3));

    // Simultaneous enqueue and dequeue
    repeat (2) tick();
    bus.u_r_ready = 1'b0;
    rx_q.delete();
    send_pixel(4);
    check("sim_pre_level", 72'(bus.level), 72'd1);
    send_words(5, 0, 4);
    bus.u_r_ready = 1'b1;
    send_words(5, 5, 5);
    check("sim_level", 72'(bus.level), 72'd1);
    check("sim_head",  bus.data_out,    pix_of(5));
    wait_rx(2);
    check("sim_rx0", rx_q[0], pix_of(4));
    check("sim_rx1", rx_q[1], pix_of(5));

    // Framing: sop in the middle of a pixel
    repeat (2) tick();
    rx_q.delete();
    fe0 = fe_count;
    send_word(12'h101, 1'b1);
    send_word(12'h102, 1'b0);
    send_word(12'h103, 1'b0);
    send_word(12'hAAA, 1'b1);
    check("fe_mid_pulse", 72'(bus.framing_error), 72'd1);
    send_word(12'hBBB, 1'b0);
    send_word(12'hCCC, 1'b0);
    send_word(12'hDDD, 1'b0);
    send_word(12'hEEE, 1'b0);
    send_word(12'hFFF, 1'b0);
    wait_rx(1);
    repeat (2) tick();
    check("fe_mid_count", 72'(fe_count - fe0), 72'd1);
    check("fe_mid_pixel", rx_q[0], 72'hAAABBBCCCDDDEEEFFF);
    check("fe_mid_rx_n",  72'(rx_q.size()), 72'd1);

    // Framing: leading word without sop after reset
    do_reset();
    rx_q.delete();
    fe0 = fe_count;
    send_word(12'h777, 1'b0);
    check("fe_lead_pulse", 72'(bus.framing_error), 72'd1);
    send_pixel(6);
    wait_rx(1);
    repeat (2) tick();
    check("fe_lead_count", 72'(fe_count - fe0), 72'd1);
    check("fe_lead_pixel", rx_q[0], pix_of(6));

    // Pointer wrap with random downstream stalls
    rx_q.delete();
    max_level = 0;
    rand_en   = 1'b1;
    fork
      begin
        for (int p = 10; p < 20; p++) send_pixel(p);
        rand_en = 1'b0;
      end
      begin
        while (rand_en) begin
          bus.u_r_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.u_r_ready = 1'b1;
    wait_rx(10);
    for (int i = 0; i < 10; i++) check($sformatf("wrap_pix%0d", i), rx_q[i], pix_of(10 + i));
    check("wrap_max_level", 72'(max_level <= 2), 72'd1);

    // Reset mid-operation
    repeat (2) tick();
    bus.u_r_ready = 1'b0;
    send_pixel(30);
    send_words(31, 0, 2);
    check("mid_pre_level", 72'(bus.level), 72'd1);
    fe0 = fe_count;
    reset = 1'b1;
    tick();
    check("mid_i_r_ready", 72'(bus.i_r_ready), 72'd0);
    check("mid_data_out",  bus.data_out,       72'd0);
    check("mid_level",     72'(bus.level),     72'd0);
    check("mid_i_i_ready", 72'(bus.i_i_ready), 72'd1);
    reset = 1'b0;
    bus.u_r_ready = 1'b1;
    rx_q.delete();
    send_pixel(32);
    wait_rx(1);
    repeat (2) tick();
    check("mid_after_pixel", rx_q[0], pix_of(32));
    check("mid_no_fe", 72'(fe_count - fe0), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
